// File: rtl/i2c_slave_arbiter.sv
// Arbitrates one I2C frontend among four address-decoded peripheral ports.
// Optional transaction watchdog enabled by defining I2C_ARB_WATCHDOG_EN.
module i2c_slave_arbiter #(
    parameter logic [6:0]  ADDR0   = 7'h21,
    parameter logic [6:0]  ADDR1   = 7'h22,
    parameter logic [6:0]  ADDR2   = 7'h23,
    parameter logic [6:0]  ADDR3   = 7'h24,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] fe_rx,
    output logic [1:0]  fe_tx,
    output logic [79:0] port_rx,
    input  logic [7:0]  port_tx,
    output logic [1:0]  sel,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_IGNORE = 2'd2
    } state_t;

    localparam logic [3:0] STB_STOP = 4'b0010;

    state_t      state_r;
    state_t      state_n;
    logic [1:0]  sel_r;
    logic [1:0]  sel_n;
    logic        busy_r;
    logic [1:0]  fe_tx_r;
    logic [79:0] port_rx_r;
    logic [79:0] port_rx_n;
    logic [3:0]  strobe_n;
    logic        start_s;
    logic        stop_s;
    logic        any_strobe_s;
    logic        fire_s;
    logic [2:0]  dec_s;

    // Lowest-index match wins when several ports share an address.
    function automatic logic [2:0] decode_addr(input logic [6:0] addr);
        logic [2:0] r;
        if (addr == ADDR0) begin
            r = {1'b1, 2'd0};
        end else if (addr == ADDR1) begin
            r = {1'b1, 2'd1};
        end else if (addr == ADDR2) begin
            r = {1'b1, 2'd2};
        end else if (addr == ADDR3) begin
            r = {1'b1, 2'd3};
        end else begin
            r = 3'b000;
        end
        return r;
    endfunction

    assign start_s      = fe_rx[16];
    assign stop_s       = fe_rx[17];
    assign any_strobe_s = |fe_rx[19:16];
    assign dec_s        = decode_addr(fe_rx[14:8]);

`ifdef I2C_ARB_WATCHDOG_EN
    logic [15:0] wd_cnt_r;
    logic        timeout_r;

    assign fire_s  = (state_r == ST_ACTIVE) && !any_strobe_s && (wd_cnt_r == TIMEOUT);
    assign timeout = timeout_r;

    // Watchdog counter and sticky timeout flag; a start rearms both.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_r  <= 16'd0;
            timeout_r <= 1'b0;
        end else if (start_s) begin
            wd_cnt_r  <= 16'd0;
            timeout_r <= 1'b0;
        end else if (state_r == ST_ACTIVE) begin
            if (any_strobe_s) begin
                wd_cnt_r <= 16'd0;
            end else if (fire_s) begin
                wd_cnt_r  <= 16'd0;
                timeout_r <= 1'b1;
            end else if (wd_cnt_r != 16'hFFFF) begin
                wd_cnt_r <= wd_cnt_r + 16'd1;
            end else begin
                wd_cnt_r <= wd_cnt_r;
            end
        end else begin
            wd_cnt_r <= 16'd0;
        end
    end
`else
    logic unused_timeout_cfg_s;

    assign unused_timeout_cfg_s = ^TIMEOUT;
    assign fire_s  = 1'b0;
    assign timeout = 1'b0;
`endif

    // Next grant and the strobes forwarded to the post-decode selection.
    always_comb begin
        state_n  = state_r;
        sel_n    = sel_r;
        strobe_n = 4'b0000;
        if (start_s) begin
            if (dec_s[2]) begin
                state_n  = ST_ACTIVE;
                sel_n    = dec_s[1:0];
                strobe_n = fe_rx[19:16] & 4'b1101;
            end else begin
                state_n = ST_IGNORE;
            end
        end else if (state_r == ST_ACTIVE) begin
            strobe_n = fe_rx[19:16];
            if (stop_s) begin
                state_n = ST_IDLE;
            end else if (fire_s) begin
                state_n  = ST_IDLE;
                strobe_n = STB_STOP;
            end else begin
                state_n = ST_ACTIVE;
            end
        end else if ((state_r == ST_IGNORE) && stop_s) begin
            state_n = ST_IDLE;
        end else begin
            state_n = state_r;
        end
    end

    // Data fields fan out to every port; strobes only to the granted one.
    always_comb begin
        port_rx_n = 80'd0;
        for (int i = 0; i < 4; i++) begin
            port_rx_n[20*i +: 20] = {(sel_n == 2'(i)) ? strobe_n : 4'b0000, fe_rx[15:0]};
        end
    end

    // Grant state and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            sel_r     <= 2'd0;
            busy_r    <= 1'b0;
            fe_tx_r   <= 2'b00;
            port_rx_r <= 80'd0;
        end else begin
            state_r   <= state_n;
            sel_r     <= sel_n;
            busy_r    <= (state_n == ST_ACTIVE);
            port_rx_r <= port_rx_n;
            fe_tx_r   <= (state_r == ST_ACTIVE) ? port_tx[{sel_r, 1'b0} +: 2] : 2'b00;
        end
    end

    assign fe_tx   = fe_tx_r;
    assign port_rx = port_rx_r;
    assign sel     = sel_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_i2c_slave_arbiter.sv
// Directed vector bench for i2c_slave_arbiter, plus a duplicate-address instance.
module tb_i2c_slave_arbiter;

    localparam logic [3:0] STA = 4'b0001;
    localparam logic [3:0] STP = 4'b0010;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] RD  = 4'b1000;
    localparam logic [3:0] NON = 4'b0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] fe_rx = 20'd0;
    logic [7:0]  port_tx = 8'd0;
    logic [1:0]  fe_tx, d_fe_tx;
    logic [79:0] port_rx, d_port_rx;
    logic [1:0]  sel, d_sel;
    logic        busy, d_busy, timeout, d_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    i2c_slave_arbiter #(.TIMEOUT(16'd100)) dut (
        .clk(clk), .reset(reset), .fe_rx(fe_rx), .fe_tx(fe_tx), .port_rx(port_rx),
        .port_tx(port_tx), .sel(sel), .busy(busy), .timeout(timeout)
    );

    i2c_slave_arbiter #(.ADDR1(7'h30), .ADDR2(7'h30), .TIMEOUT(16'd100)) u_dup (
        .clk(clk), .reset(reset), .fe_rx(fe_rx), .fe_tx(d_fe_tx), .port_rx(d_port_rx),
        .port_tx(port_tx), .sel(d_sel), .busy(d_busy), .timeout(d_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] rx;
        logic [7:0]  ptx;
        logic [79:0] prx;
        logic [1:0]  ftx;
        logic        bsy;
        logic [1:0]  sl;
    } vec_t;

    vec_t vt[18];
    int   nv = 0;

    function automatic logic [19:0] mkrx(logic [3:0] stb, logic rw, logic [6:0] a, logic [7:0] d);
        return {stb, rw, a, d};
    endfunction

    // Port p gets strobes stb; p outside 0..3 means no port gets strobes.
    function automatic logic [79:0] mkprx(int p, logic [3:0] stb, logic [15:0] lo);
        logic [79:0] r;
        for (int i = 0; i < 4; i++) r[20*i +: 20] = {(i == p) ? stb : 4'b0000, lo};
        return r;
    endfunction

    task automatic add(input logic [19:0] rx, input logic [7:0] ptx, input int p,
                       input logic [3:0] stb, input logic [1:0] ftx, input logic bsy,
                       input logic [1:0] sl);
        vt[nv].rx  = rx;
        vt[nv].ptx = ptx;
        vt[nv].prx = mkprx(p, stb, rx[15:0]);
        vt[nv].ftx = ftx;
        vt[nv].bsy = bsy;
        vt[nv].sl  = sl;
        nv++;
    endtask

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        // Plain transaction to port 1.
        add(mkrx(STA, 1'b0, 7'h22, 8'h00), 8'h00, 1, STA, 2'b00, 1'b1, 2'd1);
        add(mkrx(NON, 1'b0, 7'h22, 8'hA5), 8'hF7, 4, NON, 2'b01, 1'b1, 2'd1);
        add(mkrx(WR,  1'b0, 7'h22, 8'hA5), 8'hF7, 1, WR,  2'b01, 1'b1, 2'd1);
        add(mkrx(NON, 1'b0, 7'h22, 8'hA5), 8'hF3, 4, NON, 2'b00, 1'b1, 2'd1);
        add(mkrx(STP, 1'b0, 7'h22, 8'hA5), 8'hFB, 1, STP, 2'b10, 1'b0, 2'd1);
        add(mkrx(NON, 1'b0, 7'h22, 8'h00), 8'hFF, 4, NON, 2'b00, 1'b0, 2'd0);
        // Unmatched address.
        add(mkrx(STA, 1'b0, 7'h50, 8'h00), 8'hFF, 4, NON, 2'b00, 1'b0, 2'd0);
        add(mkrx(WR,  1'b0, 7'h50, 8'h12), 8'hFF, 4, NON, 2'b00, 1'b0, 2'd0);
        add(mkrx(STP, 1'b0, 7'h50, 8'h12), 8'hFF, 4, NON, 2'b00, 1'b0, 2'd0);
        add(mkrx(NON, 1'b0, 7'h50, 8'h00), 8'hFF, 4, NON, 2'b00, 1'b0, 2'd0);
        // Repeated start from port 0 to port 2.
        add(mkrx(STA, 1'b0, 7'h21, 8'h00), 8'h00, 0, STA, 2'b00, 1'b1, 2'd0);
        add(mkrx(WR,  1'b0, 7'h21, 8'h3C), 8'h01, 0, WR,  2'b01, 1'b1, 2'd0);
        add(mkrx(STA, 1'b1, 7'h23, 8'h00), 8'h01, 2, STA, 2'b01, 1'b1, 2'd2);
        add(mkrx(RD,  1'b1, 7'h23, 8'h00), 8'h20, 2, RD,  2'b10, 1'b1, 2'd2);
        add(mkrx(STP, 1'b1, 7'h23, 8'h00), 8'h00, 2, STP, 2'b00, 1'b0, 2'd2);
        // Start and stop together: start wins.
        add(mkrx(STA | STP, 1'b0, 7'h24, 8'h00), 8'h00, 3, STA, 2'b00, 1'b1, 2'd3);
        add(mkrx(STP, 1'b0, 7'h24, 8'h00), 8'hC0, 3, STP, 2'b11, 1'b0, 2'd3);
        add(mkrx(STP, 1'b0, 7'h24, 8'h00), 8'h00, 4, NON, 2'b00, 1'b0, 2'd3);

        #3;
        chk("rst_port_rx", port_rx, 80'd0);
        chk("rst_fe_tx", {78'd0, fe_tx}, 80'd0);
        chk("rst_busy_sel_to", {76'd0, busy, sel, timeout}, 80'd0);
        step();
        reset = 1'b1;

        for (int i = 0; i < nv; i++) begin
            fe_rx   = vt[i].rx;
            port_tx = vt[i].ptx;
            step();
            chk($sformatf("v%0d_port_rx", i), port_rx, vt[i].prx);
            chk($sformatf("v%0d_fe_tx", i), {78'd0, fe_tx}, {78'd0, vt[i].ftx});
            chk($sformatf("v%0d_busy", i), {79'd0, busy}, {79'd0, vt[i].bsy});
            chk($sformatf("v%0d_timeout", i), {79'd0, timeout}, 80'd0);
            if (vt[i].bsy) chk($sformatf("v%0d_sel", i), {78'd0, sel}, {78'd0, vt[i].sl});
        end

        // Shared address 7'h30 on ports 1 and 2 of the second instance.
        fe_rx = mkrx(STA, 1'b0, 7'h30, 8'h00);
        port_tx = 8'h00;
        step();
        chk("dup_sel", {77'd0, d_busy, d_sel}, {77'd0, 1'b1, 2'd1});
        chk("dup_port_rx", d_port_rx, mkprx(1, STA, fe_rx[15:0]));
        chk("dup_main_ignored", {79'd0, busy}, 80'd0);
        fe_rx = mkrx(STP, 1'b0, 7'h30, 8'h00);
        step();
        chk("dup_stop", d_port_rx, mkprx(1, STP, fe_rx[15:0]));

        // Asynchronous reset in the middle of a port 0 transaction.
        fe_rx = mkrx(STA, 1'b0, 7'h21, 8'h00);
        step();
        fe_rx = mkrx(NON, 1'b0, 7'h21, 8'h5A);
        port_tx = 8'h01;
        step();
        chk("pre_rst_fe_tx", {78'd0, fe_tx}, 80'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_port_rx", port_rx, 80'd0);
        chk("mid_rst_outs", {76'd0, fe_tx, busy, sel, timeout}, 80'd0);
        step();
        reset = 1'b1;
        fe_rx = mkrx(STA, 1'b0, 7'h22, 8'h00);
        port_tx = 8'h00;
        step();
        chk("post_rst_start", port_rx, mkprx(1, STA, fe_rx[15:0]));
        chk("post_rst_sel", {77'd0, busy, sel}, {77'd0, 1'b1, 2'd1});
        fe_rx = mkrx(STP, 1'b0, 7'h22, 8'h00);
        step();

        // Watchdog: start to port 3, then silence.
        fe_rx = mkrx(STA, 1'b0, 7'h24, 8'h00);
        step();
        fe_rx = mkrx(NON, 1'b0, 7'h24, 8'h00);
        bad = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (busy !== 1'b1 || port_rx !== mkprx(4, NON, fe_rx[15:0])) bad++;
        end
        chk("wd_hold", bad, 0);
`ifdef I2C_ARB_WATCHDOG_EN
        step();
        chk("wd_fire_stop", port_rx, mkprx(3, STP, fe_rx[15:0]));
        chk("wd_fire_flags", {78'd0, busy, timeout}, {78'd0, 1'b0, 1'b1});
        step();
        chk("wd_one_pulse", port_rx, mkprx(4, NON, fe_rx[15:0]));
        chk("wd_sticky", {79'd0, timeout}, 80'd1);
        fe_rx = mkrx(STA, 1'b0, 7'h21, 8'h00);
        step();
        chk("wd_clear", {78'd0, busy, timeout}, {78'd0, 1'b1, 1'b0});
`else
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (busy !== 1'b1 || timeout !== 1'b0 || port_rx !== mkprx(4, NON, fe_rx[15:0])) bad++;
        end
        chk("nowd_busy_held", bad, 0);
`endif
        fe_rx = mkrx(STP, 1'b0, 7'h24, 8'h00);
        step();
        fe_rx = 20'd0;
        step();
        chk("final_idle", {79'd0, busy}, 80'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave_arbiter.md
# i2c_slave_arbiter

Shares the single `i2c_frontend` bus pair (20-bit receive, 2-bit transmit) among four I2C-addressable peripherals (e.g. `pwm_i2c` instances). On each START/address event it decodes the 7-bit address and grants exactly one port. It forwards events only to that port and returns only that port's ACK/data-out to the frontend. A transaction watchdog releases the bus if a STOP never arrives.

## Interface

Parameters:
- `ADDR0`, default 7'h21, address owned by port 0
- `ADDR1`, default 7'h22, address owned by port 1
- `ADDR2`, default 7'h23, address owned by port 2
- `ADDR3`, default 7'h24, address owned by port 3
- `TIMEOUT`, default 16'd50000, idle cycles in ACTIVE before forced release; 16-bit

Ports:
- `clk`, input, 1, system clock; all logic on rising edge
- `reset`, input, 1, asynchronous, active-low; clears all state
- `fe_rx`, input, 20, from frontend: [7:0] data, [14:8] address, [15] R/W, [16] start strobe, [17] stop strobe, [18] byte-written strobe, [19] byte-read strobe
- `fe_tx`, output, 2, to frontend: [0] ACK request, [1] read data bit
- `port_rx`, output, 80, port n on [20n+19:20n], same field layout as `fe_rx`
- `port_tx`, input, 8, port n on [2n+1:2n], same layout as `fe_tx`
- `sel`, output, 2, index of granted port; valid while `busy`
- `busy`, output, 1, a port is granted
- `timeout`, output, 1, sticky; watchdog fired since last start

## Operation

- States:
  - IDLE: no grant.
  - ACTIVE: `sel` granted.
  - IGNORE: address matched no port.
- Any state, `fe_rx[16]`=1 (start, including repeated start): compare `fe_rx[14:8]` with ADDR0..3.
  - On match, go to ACTIVE with `sel` = lowest matching index.
  - On no match, go to IGNORE.
  - `timeout` clears. Watchdog clears.
- ACTIVE, `fe_rx[17]`=1 (stop): stop is forwarded to `sel`, then go to IDLE.
- IGNORE, stop: go to IDLE.
- IDLE, stop: no effect.
- Start and stop in the same cycle: start wins; stop is discarded.
- `port_rx` is registered.
  - Data/address/RW fields [15:0] are copied to all four ports every cycle.
  - Strobes [19:16] go only to the port granted by the post-decode selection. All other ports see 0 on [19:16].
  - The start strobe therefore reaches only the newly granted port. On a repeated start to another port, the old port receives no stop.
- `fe_tx` is registered.
  - ACTIVE: `port_tx` of `sel`.
  - IDLE or IGNORE: 2'b00, so an unmatched address is NACKed.
- Watchdog: 16-bit counter, runs only in ACTIVE.
  - Clears on any strobe in `fe_rx[19:16]`.
  - When the counter equals TIMEOUT: one-cycle synthesized stop (`port_rx[20*sel+17]`=1) to `sel`, set `timeout`, go to IDLE.
  - Counter saturates; it never wraps.
- Reset (async, any time, including mid-transaction):
  - State IDLE; `sel`=0, `busy`=0, `timeout`=0.
  - `port_rx` all 0; `fe_tx`=2'b00; counter 0.
  - No stop is synthesized to the interrupted port.

## Timing

- `fe_rx` to `port_rx`: 1 cycle latency, for data and strobes alike.
- `port_tx` to `fe_tx`: 1 cycle latency.
  - Frontend must tolerate a 2-cycle round trip from strobe to ACK/data.
- `busy`/`sel` update in the cycle after the start strobe, aligned with the forwarded start on `port_rx`.
- Stop: forwarded stop and deassertion of `busy` appear in the same cycle.
- Watchdog: forced stop appears TIMEOUT+1 cycles after the last strobe.

## Configuration

- `I2C_ARB_WATCHDOG_EN` defined: watchdog counter, forced release and `timeout` output are as above.
- `I2C_ARB_WATCHDOG_EN` undefined:
  - No counter.
  - `timeout` is tied to 0.
  - ACTIVE leaves only on stop, restart or reset.

## Test plan

- Start with address 7'h22, W, one data byte 8'hA5, then stop:
  - `port_rx` port 1 sees start, write strobe with [7:0]=8'hA5, then stop.
  - Ports 0, 2, 3 see no strobes.
  - `busy` high from start+1 to stop+1.
  - `fe_tx` follows port 1's ACK with a 1-cycle delay.
- Start with 7'h50: state IGNORE; `fe_tx`=2'b00 throughout; no port sees strobes; stop returns to IDLE.
- ADDR1=ADDR2=7'h30, start with 7'h30: `sel`=1.
- Start 7'h21, data byte, then repeated start 7'h23 R:
  - Port 0 gets no stop.
  - Port 2 gets the start.
  - Read strobe goes to port 2.
  - `fe_tx[1]` mirrors `port_tx[5]` one cycle later.
- Watchdog (TIMEOUT=100):
  - Start 7'h24, then no strobes: at cycle 101 after the start, port 3 gets one stop pulse, `timeout`=1, `busy`=0.
  - Next start clears `timeout`.
  - With the macro undefined, `busy` stays 1 indefinitely.
- Assert `reset` low mid-transaction (ACTIVE, port 0): all outputs go to reset values immediately. After release, the state is IDLE and the next start decodes normally.
